// File: rtl/rot_input_ctrl.sv
// Rotary-encoder and push-button front end: synchronizes raw contacts, filters the
// quadrature pair into rotation steps and debounces the encoder push contact into scale changes.
module rot_input_ctrl #(
   parameter logic [19:0] DEB_MAX  = 20'hFFFFE,
   parameter logic [3:0]  IDX_MAX  = 4'h7,
   parameter logic [2:0]  SCAL_MAX = 3'h5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rot_A,
   input  logic       rot_B,
   input  logic       rot_dwn,
   input  logic       dir_sel,
   input  logic       BTN0,
   input  logic       BTN1,
   input  logic       BTN2,
   output logic [2:0] pattn,
   output logic [2:0] pattn_scal,
   output logic [3:0] rot_indx,
   output logic       step_pulse,
   output logic       step_dir,
   output logic       press_pulse
);

   logic [1:0]  ab_meta_r;
   logic [1:0]  ab_sync_r;
   logic [4:0]  misc_meta_r;
   logic [4:0]  misc_sync_r;
   logic        a_s;
   logic        b_s;
   logic        dwn_s;
   logic        dir_s;
   logic        btn0_s;
   logic        btn1_s;
   logic        btn2_s;
   logic        deb_a_r;
   logic        deb_b_r;
   logic        deb_a_d_r;
   logic        step_s;
   logic [19:0] cnt_r;
   logic        at_max_r;
   logic [2:0]  pattn_r;
   logic [2:0]  pattn_scal_r;
   logic [3:0]  rot_indx_r;
   logic        step_pulse_r;
   logic        step_dir_r;
   logic        press_pulse_r;

   function automatic logic [3:0] idx_inc(input logic [3:0] v);
      if (v >= IDX_MAX) idx_inc = 4'd0;
      else              idx_inc = v + 4'd1;
   endfunction

   function automatic logic [3:0] idx_dec(input logic [3:0] v);
      if (v == 4'd0) idx_dec = IDX_MAX;
      else           idx_dec = v - 4'd1;
   endfunction

   // Two-flop synchronizers; the quadrature pair idles high so it resets to 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ab_meta_r   <= 2'b11;
         ab_sync_r   <= 2'b11;
         misc_meta_r <= 5'b00000;
         misc_sync_r <= 5'b00000;
      end else begin
         ab_meta_r   <= {rot_A, rot_B};
         ab_sync_r   <= ab_meta_r;
         misc_meta_r <= {rot_dwn, dir_sel, BTN0, BTN1, BTN2};
         misc_sync_r <= misc_meta_r;
      end
   end

   assign a_s    = ab_sync_r[1];
   assign b_s    = ab_sync_r[0];
   assign dwn_s  = misc_sync_r[4];
   assign dir_s  = misc_sync_r[3];
   assign btn0_s = misc_sync_r[2];
   assign btn1_s = misc_sync_r[1];
   assign btn2_s = misc_sync_r[0];

   // Quadrature filter: matching contacts move deb_a, mismatching ones move deb_b.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         deb_a_r   <= 1'b1;
         deb_b_r   <= 1'b1;
         deb_a_d_r <= 1'b1;
      end else begin
         deb_a_d_r <= deb_a_r;
         case ({a_s, b_s})
            2'b11:   deb_a_r <= 1'b1;
            2'b00:   deb_a_r <= 1'b0;
            2'b01:   deb_b_r <= 1'b1;
            2'b10:   deb_b_r <= 1'b0;
            default: begin
               deb_a_r <= deb_a_r;
               deb_b_r <= deb_b_r;
            end
         endcase
      end
   end

   assign step_s = deb_a_r & ~deb_a_d_r;

   // Rotation index with wrap in both directions.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rot_indx_r   <= 4'd0;
         step_pulse_r <= 1'b0;
         step_dir_r   <= 1'b0;
      end else begin
         step_pulse_r <= step_s;
         if (step_s) begin
            step_dir_r <= ~deb_b_r;
            rot_indx_r <= deb_b_r ? idx_dec(rot_indx_r) : idx_inc(rot_indx_r);
         end
      end
   end

   // Press debounce: saturating hold counter, one pulse when it first reaches the limit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r         <= 20'd0;
         at_max_r      <= 1'b0;
         press_pulse_r <= 1'b0;
      end else begin
         if (!dwn_s)                cnt_r <= 20'd0;
         else if (cnt_r < DEB_MAX)  cnt_r <= cnt_r + 20'd1;
         else                       cnt_r <= cnt_r;
         at_max_r      <= (cnt_r == DEB_MAX);
         press_pulse_r <= (cnt_r == DEB_MAX) & ~at_max_r;
      end
   end

   // Scale step follows the press strobe; 0 is only left by growing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pattn_scal_r <= 3'd0;
      end else if (press_pulse_r) begin
         if (dir_s && (pattn_scal_r < SCAL_MAX))       pattn_scal_r <= pattn_scal_r + 3'd1;
         else if (!dir_s && (pattn_scal_r > 3'd1))     pattn_scal_r <= pattn_scal_r - 3'd1;
         else                                          pattn_scal_r <= pattn_scal_r;
      end
   end

   // Pattern latch with BTN0 highest priority; holds when no button is pressed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pattn_r <= 3'b000;
      end else begin
         if (btn0_s)      pattn_r <= 3'b001;
         else if (btn1_s) pattn_r <= 3'b010;
         else if (btn2_s) pattn_r <= 3'b100;
         else             pattn_r <= pattn_r;
      end
   end

   assign pattn       = pattn_r;
   assign pattn_scal  = pattn_scal_r;
   assign rot_indx    = rot_indx_r;
   assign step_pulse  = step_pulse_r;
   assign step_dir    = step_dir_r;
   assign press_pulse = press_pulse_r;

endmodule

// File: tb/tb_rot_input_ctrl.sv
// Bench for rot_input_ctrl: directed scenarios plus random stimulus, all checked
// every cycle against a behavioural model built from delayed input samples.
module tb_rot_input_ctrl;

   localparam int DEB      = 16;
   localparam int IDX_MAX  = 7;
   localparam int SCAL_MAX = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rot_A = 1'b1;
   logic       rot_B = 1'b1;
   logic       rot_dwn = 1'b0;
   logic       dir_sel = 1'b0;
   logic       BTN0 = 1'b0;
   logic       BTN1 = 1'b0;
   logic       BTN2 = 1'b0;
   logic [2:0] pattn;
   logic [2:0] pattn_scal;
   logic [3:0] rot_indx;
   logic       step_pulse;
   logic       step_dir;
   logic       press_pulse;

   rot_input_ctrl #(
      .DEB_MAX (20'd16),
      .IDX_MAX (4'd7),
      .SCAL_MAX(3'd5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rot_A      (rot_A),
      .rot_B      (rot_B),
      .rot_dwn    (rot_dwn),
      .dir_sel    (dir_sel),
      .BTN0       (BTN0),
      .BTN1       (BTN1),
      .BTN2       (BTN2),
      .pattn      (pattn),
      .pattn_scal (pattn_scal),
      .rot_indx   (rot_indx),
      .step_pulse (step_pulse),
      .step_dir   (step_dir),
      .press_pulse(press_pulse)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic a;
      logic b;
      logic dwn;
      logic dir;
      logic b0;
      logic b1;
      logic b2;
   } raw_t;

   int   n_cmp = 0;
   int   n_err = 0;
   int   n_step = 0;
   int   n_press = 0;

   // Reference model state
   raw_t pipe_q[$];
   logic m_deb_a, m_deb_b, m_deb_a_old;
   int   m_run, m_idx, m_scal, m_pattn;
   logic m_step, m_dir, m_press;

   task automatic check_val(input string tag, input int obs, input int exp_v);
      n_cmp++;
      if (obs != exp_v) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      raw_t idle;
      idle = '0;
      idle.a = 1'b1;
      idle.b = 1'b1;
      pipe_q = {};
      pipe_q.push_back(idle);
      pipe_q.push_back(idle);
      m_deb_a = 1'b1; m_deb_b = 1'b1; m_deb_a_old = 1'b1;
      m_run = 0; m_idx = 0; m_scal = 0; m_pattn = 0;
      m_step = 1'b0; m_dir = 1'b0; m_press = 1'b0;
   endtask

   // Inputs seen by the logic are the raw inputs from two edges earlier.
   task automatic model_edge(input raw_t cur);
      raw_t s;
      logic step_now;
      s = pipe_q.pop_front();
      pipe_q.push_back(cur);
      step_now = m_deb_a && !m_deb_a_old;
      if (step_now) begin
         if (m_deb_b) begin
            m_idx = (m_idx + IDX_MAX) % (IDX_MAX + 1);
            m_dir = 1'b0;
         end else begin
            m_idx = (m_idx + 1) % (IDX_MAX + 1);
            m_dir = 1'b1;
         end
      end
      m_step = step_now;
      if (m_press) begin
         if (s.dir) begin
            if (m_scal < SCAL_MAX) m_scal = m_scal + 1;
         end else begin
            if (m_scal > 1) m_scal = m_scal - 1;
         end
      end
      // Pulse follows the cycle in which the held run first reaches DEB samples.
      m_press = (m_run == DEB);
      m_run   = s.dwn ? m_run + 1 : 0;
      if (s.b0)      m_pattn = 1;
      else if (s.b1) m_pattn = 2;
      else if (s.b2) m_pattn = 4;
      m_deb_a_old = m_deb_a;
      if (s.a && s.b)        m_deb_a = 1'b1;
      else if (!s.a && !s.b) m_deb_a = 1'b0;
      else if (!s.a)         m_deb_b = 1'b1;
      else                   m_deb_b = 1'b0;
   endtask

   task automatic compare_all();
      check_val("rot_indx",    int'(rot_indx),    m_idx);
      check_val("step_pulse",  int'(step_pulse),  int'(m_step));
      check_val("step_dir",    int'(step_dir),    int'(m_dir));
      check_val("press_pulse", int'(press_pulse), int'(m_press));
      check_val("pattn_scal",  int'(pattn_scal),  m_scal);
      check_val("pattn",       int'(pattn),       m_pattn);
   endtask

   task automatic tick();
      raw_t cur;
      cur.a = rot_A; cur.b = rot_B; cur.dwn = rot_dwn; cur.dir = dir_sel;
      cur.b0 = BTN0; cur.b1 = BTN1; cur.b2 = BTN2;
      @(posedge clk);
      model_edge(cur);
      #1;
      compare_all();
      if (step_pulse)  n_step++;
      if (press_pulse) n_press++;
   endtask

   // Asserts reset between edges, checks the reset state at once, releases it.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic hold_ab(input logic a, input logic b, input int n);
      rot_A = a;
      rot_B = b;
      repeat (n) tick();
   endtask

   task automatic detent(input logic fwd);
      if (fwd) begin
         hold_ab(1'b0, 1'b1, 8); hold_ab(1'b0, 1'b0, 8);
         hold_ab(1'b1, 1'b0, 8); hold_ab(1'b1, 1'b1, 8);
      end else begin
         hold_ab(1'b1, 1'b0, 8); hold_ab(1'b0, 1'b0, 8);
         hold_ab(1'b0, 1'b1, 8); hold_ab(1'b1, 1'b1, 8);
      end
   endtask

   task automatic press_hold(input int n_on, input int n_off);
      rot_dwn = 1'b1;
      repeat (n_on) tick();
      rot_dwn = 1'b0;
      repeat (n_off) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int sk;
      int ck;
      int prev_scal;
      int dwn_left;
      logic saw_zero;
      int scal_exp[6];
      scal_exp = '{1, 2, 3, 4, 5, 5};

      do_reset();

      // Forward detent and its latency (the edge that samples 11 counts as edge 1)
      hold_ab(1'b1, 1'b1, 8); hold_ab(1'b0, 1'b1, 8);
      hold_ab(1'b0, 1'b0, 8); hold_ab(1'b1, 1'b0, 8);
      rot_A = 1'b1; rot_B = 1'b1;
      lat = -1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (step_pulse && lat < 0) lat = k;
      end
      check_val("step_latency", lat, 4);
      check_val("idx_after_fwd", int'(rot_indx), 1);
      check_val("dir_after_fwd", int'(step_dir), 1);

      // Reverse wrap 0 -> 7, then eight forward detents around to 7 again
      detent(1'b0);
      check_val("idx_back_to_0", int'(rot_indx), 0);
      detent(1'b0);
      check_val("idx_wrap_down", int'(rot_indx), 7);
      check_val("dir_after_rev", int'(step_dir), 0);
      saw_zero = 1'b0;
      n_step = 0;
      for (int i = 0; i < 8; i++) begin
         detent(1'b1);
         if (rot_indx == 4'd0) saw_zero = 1'b1;
      end
      check_val("idx_full_turn", int'(rot_indx), 7);
      check_val("passed_zero", int'(saw_zero), 1);
      check_val("full_turn_steps", n_step, 8);

      // Six grow presses saturate at SCAL_MAX
      dir_sel = 1'b1;
      repeat (3) tick();
      n_press = 0;
      for (int i = 0; i < 6; i++) begin
         press_hold(20, 5);
         check_val("scale_grow", int'(pattn_scal), scal_exp[i]);
      end
      check_val("grow_pulses", n_press, 6);

      // Short holds give nothing; a long hold gives exactly one pulse
      n_press = 0;
      press_hold(10, 5);
      press_hold(10, 5);
      check_val("short_hold_pulses", n_press, 0);
      press_hold(100, 5);
      check_val("long_hold_pulses", n_press, 1);

      // Pattern priority and hold
      BTN1 = 1'b1; BTN2 = 1'b1;
      repeat (3) tick();
      BTN1 = 1'b0; BTN2 = 1'b0;
      repeat (5) tick();
      check_val("pattn_btn12", int'(pattn), 2);
      BTN0 = 1'b1;
      repeat (3) tick();
      BTN0 = 1'b0;
      repeat (5) tick();
      check_val("pattn_btn0", int'(pattn), 1);

      // Shrink to 3, then a step and a press land on the same edge
      dir_sel = 1'b0;
      repeat (3) tick();
      press_hold(20, 5);
      press_hold(20, 5);
      check_val("scale_shrink", int'(pattn_scal), 3);
      hold_ab(1'b0, 1'b1, 8); hold_ab(1'b0, 1'b0, 8); hold_ab(1'b1, 1'b0, 8);
      sk = -1; ck = -1; prev_scal = int'(pattn_scal);
      for (int k = 1; k <= 24; k++) begin
         rot_dwn = 1'b1;
         if (k == 17) begin
            rot_A = 1'b1; rot_B = 1'b1;
         end
         tick();
         if (step_pulse && sk < 0) sk = k;
         if (int'(pattn_scal) != prev_scal && ck < 0) ck = k;
      end
      check_val("coincide_step_edge", sk, 20);
      check_val("coincide_scal_edge", ck, 20);
      check_val("coincide_idx", int'(rot_indx), 0);
      check_val("coincide_scal", int'(pattn_scal), 2);
      rot_dwn = 1'b0;
      repeat (5) tick();

      // Reset at counter=10 abandons the hold; a full new hold is needed
      n_press = 0;
      rot_dwn = 1'b1;
      repeat (12) tick();
      check_val("pre_reset_pulses", n_press, 0);
      do_reset();
      n_press = 0;
      repeat (15) tick();
      check_val("post_reset_no_pulse", n_press, 0);
      repeat (10) tick();
      check_val("post_reset_new_hold", n_press, 1);
      rot_dwn = 1'b0;
      repeat (5) tick();

      // Random stimulus against the model
      dwn_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) {rot_A, rot_B} = 2'($urandom_range(0, 3));
         if (dwn_left == 0) begin
            rot_dwn  = ~rot_dwn;
            dwn_left = int'($urandom_range(1, 40));
         end else begin
            dwn_left--;
         end
         if ($urandom_range(0, 49) == 0) dir_sel = ~dir_sel;
         if ($urandom_range(0, 29) == 0) {BTN0, BTN1, BTN2} = 3'($urandom_range(0, 7));
         else {BTN0, BTN1, BTN2} = 3'b000;
         if ($urandom_range(0, 699) == 0) do_reset();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
